reg_file_sb: RTL and testbench

REG_FILE_SB -- requirements
Module: reg_file_sb

---
 rtl/reg_file_sb.sv | 89 ++++++++
 tb/tb_reg_file_sb.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_sb.sv
// Multi-port register file with zero register, same-cycle write forwarding
// and a per-register pending (scoreboard) bit with a registered population count.
module reg_file_sb #(
  parameter int DATA_W = 32,
  parameter int NREGS  = 8,
  parameter int NRD    = 3,
  parameter int BYPASS = 1,
  localparam int ADDR_W = $clog2(NREGS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NRD*ADDR_W-1:0] rd_addr,
  output logic [NRD*DATA_W-1:0] rd_data,
  output logic [NRD-1:0]        rd_busy,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_W-1:0]     wr_data_alu,
  input  logic [DATA_W-1:0]     wr_data_id,
  input  logic                  wr_sel,
  input  logic                  iss_en,
  input  logic [ADDR_W-1:0]     iss_addr,
  output logic [ADDR_W:0]       pend_cnt
);

  function automatic logic [ADDR_W:0] popcnt(input logic [NREGS-1:0] v);
    logic [ADDR_W:0] c;
    c = '0;
    for (int i = 0; i < NREGS; i++) c = c + (ADDR_W+1)'(v[i]);
    return c;
  endfunction

  logic [DATA_W-1:0] regs [NREGS];
  logic [NREGS-1:0]  pend;
  logic [NREGS-1:0]  pend_nxt;
  logic [DATA_W-1:0] wr_val;
  logic              wr_hit;
  logic              iss_hit;

  assign wr_val  = wr_sel ? wr_data_alu : wr_data_id;
  assign wr_hit  = wr_en  && (wr_addr  != '0);
  assign iss_hit = iss_en && (iss_addr != '0);

  // Issue is applied after the write clear so a same-edge claim survives.
  always_comb begin
    pend_nxt = pend;
    if (wr_hit)  pend_nxt[wr_addr]  = 1'b0;
    if (iss_hit) pend_nxt[iss_addr] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      pend     <= '0;
      pend_cnt <= '0;
    end else begin
      if (wr_hit) regs[wr_addr] <= wr_val;
      pend     <= pend_nxt;
      pend_cnt <= popcnt(pend_nxt);
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    logic              b;
    logic              fwd;

    assign a   = rd_addr[k*ADDR_W +: ADDR_W];
    assign fwd = (BYPASS != 0) && wr_hit && (wr_addr == a);

    always_comb begin
      d = regs[a];
      b = pend[a];
      if (fwd) begin
        d = wr_val;
        if (!(iss_hit && (iss_addr == a))) b = 1'b0;
      end
      // Zero register and in-reset reads never expose forwarded data.
      if (rst || (a == '0)) begin
        d = '0;
        b = 1'b0;
      end
    end

    assign rd_data[k*DATA_W +: DATA_W] = d;
    assign rd_busy[k]                  = b;
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: forwarding and non-forwarding instances share stimulus;
// expected values are queued at drive time and popped when outputs are sampled.
module tb_reg_file_sb;
  localparam int DW = 32;
  localparam int NR = 8;
  localparam int NP = 3;
  localparam int AW = 3;

  logic           clk = 1'b0;
  logic           rst;
  logic [NP*AW-1:0] rd_addr;
  logic [NP*DW-1:0] rd_data_b, rd_data_nb;
  logic [NP-1:0]  busy_b, busy_nb;
  logic           wr_en, wr_sel, iss_en;
  logic [AW-1:0]  wr_addr, iss_addr;
  logic [DW-1:0]  alu, id;
  logic [AW:0]    cnt_b, cnt_nb;

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    string       tag;
    logic [63:0] v;
  } sb_t;
  sb_t sb_q[$];

  always #5 clk = ~clk;

  reg_file_sb #(.DATA_W(DW), .NREGS(NR), .NRD(NP), .BYPASS(1)) dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_busy(busy_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data_alu(alu), .wr_data_id(id), .wr_sel(wr_sel),
    .iss_en(iss_en), .iss_addr(iss_addr), .pend_cnt(cnt_b));

  reg_file_sb #(.DATA_W(DW), .NREGS(NR), .NRD(NP), .BYPASS(0)) dut_nb (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_nb), .rd_busy(busy_nb),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data_alu(alu), .wr_data_id(id), .wr_sel(wr_sel),
    .iss_en(iss_en), .iss_addr(iss_addr), .pend_cnt(cnt_nb));

  // Behavioural reference state
  logic [DW-1:0] m_regs [NR];
  logic [NR-1:0] m_pend;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NR; i++) m_regs[i] = '0;
      m_pend = '0;
    end else begin
      if (wr_en && wr_addr != 0) begin
        m_regs[wr_addr] = wr_sel ? alu : id;
        m_pend[wr_addr] = 1'b0;
      end
      if (iss_en && iss_addr != 0) m_pend[iss_addr] = 1'b1;
    end
  end

  function automatic logic [DW-1:0] m_rd(input logic [AW-1:0] a, input bit byp);
    if (rst || a == 0) return '0;
    if (byp && wr_en && wr_addr == a) return wr_sel ? alu : id;
    return m_regs[a];
  endfunction

  function automatic logic m_busy(input logic [AW-1:0] a, input bit byp);
    if (rst || a == 0) return 1'b0;
    if (byp && wr_en && wr_addr == a && !(iss_en && iss_addr == a)) return 1'b0;
    return m_pend[a];
  endfunction

  function automatic logic [AW-1:0] ra(input int k);
    return rd_addr[k*AW +: AW];
  endfunction
  function automatic logic [DW-1:0] rd_b(input int k);
    return rd_data_b[k*DW +: DW];
  endfunction
  function automatic logic [DW-1:0] rd_nb(input int k);
    return rd_data_nb[k*DW +: DW];
  endfunction
  function automatic logic [NP*AW-1:0] pack(input logic [AW-1:0] a0, a1, a2);
    return {a2, a1, a0};
  endfunction

  task automatic exp(input string tag, input logic [63:0] v);
    sb_t e;
    e.tag = tag;
    e.v   = v;
    sb_q.push_back(e);
  endtask

  task automatic chk(input logic [63:0] obs);
    sb_t e;
    n_chk++;
    if (sb_q.size() == 0) begin
      n_err++;
      $error("FAIL sb_empty observed=%0h expected=<none>", obs);
      return;
    end
    e = sb_q.pop_front();
    assert (obs === e.v) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.v);
    end
  endtask

  task automatic idle();
    wr_en = 0; wr_sel = 0; wr_addr = 0; alu = 0; id = 0;
    iss_en = 0; iss_addr = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_model();
    for (int k = 0; k < NP; k++) begin
      exp($sformatf("rnd_rd_b%0d", k), m_rd(ra(k), 1));
      exp($sformatf("rnd_rd_nb%0d", k), m_rd(ra(k), 0));
      exp($sformatf("rnd_busy_b%0d", k), m_busy(ra(k), 1));
      exp($sformatf("rnd_busy_nb%0d", k), m_busy(ra(k), 0));
    end
    exp("rnd_cnt_b", $countones(m_pend));
    exp("rnd_cnt_nb", $countones(m_pend));
    for (int k = 0; k < NP; k++) begin
      chk(rd_b(k));
      chk(rd_nb(k));
      chk(busy_b[k]);
      chk(busy_nb[k]);
    end
    chk(cnt_b);
    chk(cnt_nb);
  endtask

  initial begin
    rst = 1; idle(); rd_addr = pack(1, 2, 3);
    @(negedge clk); #1;
    exp("rst_cnt", 0);  chk(cnt_b);
    exp("rst_rd0", 0);  chk(rd_b(0));
    exp("rst_busy", 0); chk(busy_b);
    @(negedge clk); rst = 0;

    // Write then read back
    wr_en = 1; wr_addr = 3; wr_sel = 1; alu = 32'hDEADBEEF;
    tick(); idle(); rd_addr = pack(3, 0, 0); #1;
    exp("rd_after_wr_b", 32'hDEADBEEF);  chk(rd_b(0));
    exp("rd_after_wr_nb", 32'hDEADBEEF); chk(rd_nb(0));

    // Zero register
    wr_en = 1; wr_addr = 0; id = 32'h1234; wr_sel = 0; rd_addr = pack(0, 0, 0); #1;
    exp("zero_byp", 0); chk(rd_b(0));
    tick(); idle(); #1;
    for (int k = 0; k < NP; k++) begin
      exp($sformatf("zero_rd%0d", k), 0); chk(rd_b(k));
    end
    exp("zero_cnt", 0); chk(cnt_b);

    // Forwarding versus old value
    wr_en = 1; wr_addr = 5; id = 32'h11111111; wr_sel = 0;
    tick();
    wr_en = 1; wr_addr = 5; id = 32'hA5A5A5A5; wr_sel = 0; rd_addr = pack(0, 5, 0); #1;
    exp("byp_fwd", 32'hA5A5A5A5); chk(rd_b(1));
    exp("nobyp_old", 32'h11111111); chk(rd_nb(1));
    tick(); idle(); #1;
    exp("nobyp_after", 32'hA5A5A5A5); chk(rd_nb(1));

    // Pending set and clear
    iss_en = 1; iss_addr = 2; tick();
    iss_addr = 4; tick(); idle(); rd_addr = pack(2, 4, 0); #1;
    exp("pend_cnt2", 2);  chk(cnt_b);
    exp("busy2_set", 1);  chk(busy_b[0]);
    exp("busy4_set", 1);  chk(busy_b[1]);
    wr_en = 1; wr_addr = 2; alu = 32'h2222; wr_sel = 1; #1;
    exp("busy2_fwd_clr", 0); chk(busy_b[0]);
    exp("busy2_nb_held", 1); chk(busy_nb[0]);
    tick(); idle(); #1;
    exp("pend_cnt1", 1);    chk(cnt_b);
    exp("busy2_clr", 0);    chk(busy_b[0]);
    exp("busy2_nb_clr", 0); chk(busy_nb[0]);

    // Issue wins over same-edge write
    iss_en = 1; iss_addr = 6; tick(); idle(); #1;
    exp("pend_cnt_6", 2); chk(cnt_b);
    iss_en = 1; iss_addr = 6; wr_en = 1; wr_addr = 6; id = 32'h66666666; wr_sel = 0;
    rd_addr = pack(0, 0, 6); #1;
    exp("busy6_iss_wins", 1); chk(busy_b[2]);
    tick(); idle(); #1;
    exp("rd6_written", 32'h66666666); chk(rd_b(2));
    exp("busy6_held", 1);             chk(busy_b[2]);
    exp("cnt_unchanged", 2);          chk(cnt_b);

    // Re-issue, write to idle register, issue to zero register
    iss_en = 1; iss_addr = 4; tick();
    iss_en = 1; iss_addr = 0; wr_en = 1; wr_addr = 7; id = 32'h77; wr_sel = 0;
    tick(); idle(); rd_addr = pack(7, 0, 4); #1;
    exp("cnt_no_change", 2); chk(cnt_b);
    exp("rd7", 32'h77);      chk(rd_b(0));
    exp("busy0", 0);         chk(busy_b[1]);
    exp("busy4", 1);         chk(busy_b[2]);

    // Asynchronous reset between edges
    iss_en = 1; iss_addr = 1; tick(); idle(); #1;
    exp("pend_cnt3", 3); chk(cnt_b);
    wr_en = 1; wr_addr = 3; alu = 32'hCAFEF00D; wr_sel = 1; iss_en = 1; iss_addr = 5;
    rd_addr = pack(3, 6, 1);
    #1; rst = 1; #1;
    for (int k = 0; k < NP; k++) begin
      exp($sformatf("arst_rd_b%0d", k), 0);  chk(rd_b(k));
      exp($sformatf("arst_rd_nb%0d", k), 0); chk(rd_nb(k));
    end
    exp("arst_busy_b", 0);  chk(busy_b);
    exp("arst_busy_nb", 0); chk(busy_nb);
    exp("arst_cnt", 0);     chk(cnt_b);
    tick(); #1;
    exp("rst_discard_cnt", 0); chk(cnt_b);
    rst = 0; idle(); tick(); #1;
    exp("post_rst_rd3", 0);  chk(rd_b(0));
    exp("post_rst_cnt", 0);  chk(cnt_b);

    // Random traffic against the reference model
    for (int n = 0; n < 60; n++) begin
      wr_en    = 1'($urandom_range(0, 1));
      wr_addr  = AW'($urandom_range(0, NR-1));
      wr_sel   = 1'($urandom_range(0, 1));
      alu      = $urandom;
      id       = $urandom;
      iss_en   = 1'($urandom_range(0, 1));
      iss_addr = AW'($urandom_range(0, NR-1));
      rd_addr  = pack(AW'($urandom_range(0, NR-1)), AW'($urandom_range(0, NR-1)),
                      (n % 4 == 0) ? wr_addr : AW'($urandom_range(0, NR-1)));
      #1;
      check_model();
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
